// File: rtl/cent_vga_scan.sv
// VGA raster generator with a 2x-upscaled game window fetched from a 1-cycle pixel source.
// Three registered stages keep sync and colour aligned at the pins.
module cent_vga_scan #(
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         WIN_X0     = 64,
  parameter int         WIN_Y0     = 0,
  parameter int         WIN_W      = 256,
  parameter int         WIN_H      = 240,
  parameter logic [2:0] BORDER_RGB = 3'b000
) (
  input  logic       clk_vga,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_start,
  output logic       pix_req,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  input  logic [2:0] pix_rgb,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int WIN_X1   = WIN_X0 + 2 * WIN_W;
  localparam int WIN_Y1   = WIN_Y0 + 2 * WIN_H;

  // raster counters
  logic [9:0] hcount_reg, vcount_reg;

  // stage 1: request to the pixel source plus control flags
  logic       frame_start_reg;
  logic       pix_req_reg;
  logic [7:0] pix_x_reg, pix_y_reg;
  logic       active_s1_reg, hs_s1_reg, vs_s1_reg;

  // stage 2: flags aligned with the returning pix_rgb
  logic       active_s2_reg, in_win_s2_reg, hs_s2_reg, vs_s2_reg;

  // stage 3: pin registers
  logic       hsync_reg, vsync_reg;
  logic [2:0] rgb_reg;

  int         h_int, v_int;
  logic       h_last, v_last;
  logic       req_next, active_next, hs_next, vs_next, fs_next;
  logic [7:0] pix_x_next, pix_y_next;
  logic [2:0] rgb_next;

  always_comb begin
    h_int       = int'({22'd0, hcount_reg});
    v_int       = int'({22'd0, vcount_reg});
    h_last      = (h_int == H_TOTAL - 1);
    v_last      = (v_int == V_TOTAL - 1);
    req_next    = (h_int >= WIN_X0) && (h_int < WIN_X1) &&
                  (v_int >= WIN_Y0) && (v_int < WIN_Y1);
    active_next = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
    hs_next     = (h_int >= HS_START) && (h_int < HS_END);
    vs_next     = (v_int >= VS_START) && (v_int < VS_END);
    fs_next     = (h_int == 0) && (v_int == 0);
    pix_x_next  = 8'd0;
    pix_y_next  = 8'd0;
    // Each game pixel spans two columns and two lines; drop the LSB of the window offset.
    if (req_next) begin
      pix_x_next = 8'((h_int - WIN_X0) >> 1);
      pix_y_next = 8'((v_int - WIN_Y0) >> 1);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      hcount_reg <= '0;
      vcount_reg <= '0;
    end else begin
      hcount_reg <= h_last ? 10'd0 : hcount_reg + 10'd1;
      if (h_last) begin
        vcount_reg <= v_last ? 10'd0 : vcount_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      frame_start_reg <= 1'b0;
      pix_req_reg     <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      active_s1_reg   <= 1'b0;
      hs_s1_reg       <= 1'b0;
      vs_s1_reg       <= 1'b0;
      active_s2_reg   <= 1'b0;
      in_win_s2_reg   <= 1'b0;
      hs_s2_reg       <= 1'b0;
      vs_s2_reg       <= 1'b0;
    end else begin
      frame_start_reg <= fs_next;
      pix_req_reg     <= req_next;
      pix_x_reg       <= pix_x_next;
      pix_y_reg       <= pix_y_next;
      active_s1_reg   <= active_next;
      hs_s1_reg       <= hs_next;
      vs_s1_reg       <= vs_next;
      active_s2_reg   <= active_s1_reg;
      in_win_s2_reg   <= pix_req_reg;
      hs_s2_reg       <= hs_s1_reg;
      vs_s2_reg       <= vs_s1_reg;
    end
  end

  // Blanking wins over the window so an overrunning window never lights the porches.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
    assign rgb_next[gi] = active_s2_reg & (in_win_s2_reg ? pix_rgb[gi] : BORDER_RGB[gi]);
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      rgb_reg   <= 3'b000;
    end else begin
      hsync_reg <= ~hs_s2_reg;
      vsync_reg <= ~vs_s2_reg;
      rgb_reg   <= rgb_next;
    end
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign frame_start = frame_start_reg;
  assign pix_req     = pix_req_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign vga_hsync   = hsync_reg;
  assign vga_vsync   = vsync_reg;
  assign vga_r       = rgb_reg[2];
  assign vga_g       = rgb_reg[1];
  assign vga_b       = rgb_reg[0];

endmodule
